// File: rtl/shift_issue_ctrl.sv
// shift_issue_ctrl: accepts shift requests, sequences the sq_shift
// clear/enable/operand inputs, waits for completion (or a timeout) and
// returns the result or an error over a valid/ready response channel.
// Illegal opcodes and zero-amount shifts are answered without using the shifter.
module shift_issue_ctrl #(
    parameter int OP_SZ   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [OP_SZ-1:0]         req_data,
    input  logic [$clog2(OP_SZ)-1:0] req_amt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [OP_SZ-1:0]         rsp_data,
    output logic [1:0]               rsp_err,
    output logic                     sh_en,
    output logic [3:0]               sh_op,
    output logic                     sh_reset,
    output logic [OP_SZ-1:0]         sh_data,
    output logic [$clog2(OP_SZ)-1:0] sh_shift_value,
    input  logic [OP_SZ-1:0]         sh_out,
    input  logic                     sh_op_done
);

    localparam int AMT_W = $clog2(OP_SZ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SRL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [3:0]         r_op;
    logic [OP_SZ-1:0]   r_data;
    logic [AMT_W-1:0]   r_amt;
    logic [OP_SZ-1:0]   r_rsp_data;
    logic [1:0]         r_rsp_err;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_accept;
    logic               w_legal;
    logic               w_zero_amt;
    logic               w_timeout;

    assign w_accept   = req_valid && (r_state == IDLE);
    assign w_legal    = (req_op == OP_SLL) || (req_op == OP_SRL) || (req_op == OP_SRA);
    assign w_zero_amt = (req_amt == '0);
    assign w_timeout  = (r_cnt == CNT_LAST);

    assign sh_op          = r_op;
    assign sh_data        = r_data;
    assign sh_shift_value = r_amt;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;

    // State register; reset drops any in-flight op and parks in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the handshake/shifter controls decoded from state.
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        sh_en     = 1'b0;
        sh_reset  = 1'b1;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (w_accept) begin
                    w_next = (!w_legal || w_zero_amt) ? RESP : LOAD;
                end
            end
            LOAD: begin
                sh_en  = 1'b1;
                w_next = RUN;
            end
            RUN: begin
                sh_en    = 1'b1;
                sh_reset = 1'b0;
                if (sh_op_done || w_timeout) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand registers, loaded only on the accept cycle and held through RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op   <= '0;
            r_data <= '0;
            r_amt  <= '0;
        end else if (w_accept) begin
            r_op   <= req_op;
            r_data <= req_data;
            r_amt  <= req_amt;
        end
    end

    // Response capture and RUN timeout counter; done beats timeout on the last cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rsp_data <= '0;
            r_rsp_err  <= ERR_OK;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (!w_legal) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= ERR_ILLEGAL;
                        end else if (w_zero_amt) begin
                            r_rsp_data <= req_data;
                            r_rsp_err  <= ERR_OK;
                        end
                    end
                end
                LOAD: begin
                    r_cnt <= '0;
                end
                RUN: begin
                    if (sh_op_done) begin
                        r_rsp_data <= sh_out;
                        r_rsp_err  <= ERR_OK;
                    end else if (w_timeout) begin
                        r_rsp_data <= '0;
                        r_rsp_err  <= ERR_TIMEOUT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_issue_ctrl.md
# shift_issue_ctrl

Issue controller that sits directly upstream of the sequential shifter (`sq_shift`) in the MCU datapath. It accepts shift requests over a valid/ready handshake and decodes the opcode. It sequences the shifter's clear/enable/operand inputs, waits for `op_done`, and returns the result (or an error) over a valid/ready response channel. Illegal opcodes, zero-amount shifts and hung shifter operations are handled locally, so the shifter never stalls the pipeline indefinitely.

## Interface
Parameters:
- `OP_SZ`, 32: operand/result width; must match the shifter's `op_sz`.
- `TIMEOUT`, 40: max RUN cycles to wait for `sh_op_done` before aborting; must be ≥ OP_SZ+2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request.
- `req_op`  in  4  opcode: 8 = logical left, 9 = logical right, 10 = arithmetic right.
- `req_data`  in  OP_SZ  operand.
- `req_amt`  in  $clog2(OP_SZ)  shift amount.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  OP_SZ  result.
- `rsp_err`  out  2  00 ok, 01 illegal op, 10 timeout.
- `sh_en`  out  1  shifter enable.
- `sh_op`  out  4  shifter opcode.
- `sh_reset`  out  1  shifter clear (active-high).
- `sh_data`  out  OP_SZ  shifter operand.
- `sh_shift_value`  out  $clog2(OP_SZ)  shifter amount.
- `sh_out`  in  OP_SZ  shifter result.
- `sh_op_done`  in  1  shifter completion.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE:
  - `req_ready`=1, `sh_reset`=1, `sh_en`=0.
  - On `req_valid`, register op/data/amt and decode:
    - Op not in {8,9,10}: go to RESP with `rsp_err`=01 and `rsp_data`=0.
    - `req_amt`=0: go to RESP with `rsp_err`=00 and `rsp_data`=`req_data` (bypass; the shifter is not used).
    - Otherwise: go to LOAD.
- LOAD, exactly 1 cycle: `sh_reset`=1, `sh_en`=1, operands driven from the registers. Next state is RUN.
- RUN:
  - `sh_reset`=0, `sh_en`=1; operands are held stable. A timeout counter starts at 0 on entry.
  - On `sh_op_done`=1: capture `sh_out` into `rsp_data`, set `rsp_err`=00, go to RESP.
  - If the counter reaches TIMEOUT-1 without `sh_op_done`: `rsp_data`=0, `rsp_err`=10, go to RESP.
  - `sh_op_done` and timeout in the same cycle: done wins.
- RESP:
  - `rsp_valid`=1; `rsp_data` and `rsp_err` are held until `rsp_ready`=1. Then go to IDLE.
  - `sh_reset`=1 and `sh_en`=0 (the shifter is re-cleared immediately).
  - `req_ready`=0.
- `sh_op_done` is ignored outside RUN. A level left high by the previous op is cleared by `sh_reset` in LOAD before RUN samples it.
- `req_op`, `req_data` and `req_amt` are sampled only on the accept cycle (`req_valid` & `req_ready`).

## Timing
- All outputs are registered or decoded from the state register.
- Reset values (while `reset`=0):
  - state=IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_err`=00.
  - `sh_en`=0, `sh_reset`=1, `sh_op`=0, `sh_data`=0, `sh_shift_value`=0.
- Latency, with accept at cycle N:
  - Normal op: LOAD at N+1, RUN from N+2. If `sh_op_done` is first seen at cycle M, `rsp_valid` rises at M+1.
  - Illegal op or zero-amount bypass: `rsp_valid` at N+1.
  - Timeout: `rsp_valid` at N+2+TIMEOUT.
- Throughput: one request in flight. The next accept is possible the cycle after the RESP handshake.
- Reset asserted mid-LOAD, RUN or RESP: immediate return to IDLE, the response is dropped, and `sh_reset` is forced to 1 asynchronously.
- `rsp_ready` held low: the FSM remains in RESP indefinitely with stable outputs.

## Test plan
- Op 8, data 0x0050_61B2, amt 9, behavioural shifter raising done after 9 RUN cycles -> `rsp_data`=0xA0C3_6400, `rsp_err`=00, `rsp_valid` one cycle after done.
- Back-to-back: op 9, data 18, amt 3, then op 10, data 0x8050_61B2, amt 6 -> responses 0x0000_0002 then 0xFE01_4186. `sh_reset` pulses between ops; `req_ready`=0 from the second accept until its response handshake.
- Op 3 and op 10 with amt 0 -> `rsp_err`=01 / `rsp_data`=0, and `rsp_err`=00 / `rsp_data`=operand respectively. Both at N+1, with `sh_en` never asserted.
- Shifter model never raises done, TIMEOUT=40 -> `rsp_valid` at N+42, `rsp_err`=10, `rsp_data`=0. Also drive done on the final timeout cycle -> `rsp_err`=00.
- `rsp_ready` low for 5 cycles in RESP -> `rsp_valid`, `rsp_data` and `rsp_err` stable throughout; `req_valid` during RESP is not accepted.
- `reset` low for 1 cycle in mid-RUN -> outputs return to their reset values immediately, no response is issued, and the next request completes normally.
